// File: rtl/ir_tx_pkg.sv
// Shared definitions for the IR packet transmitter.
// Provides the FSM state encoding, typical carrier periods for the four car
// colours (CLK cycles at 100 MHz), the default segment lengths (in carrier
// periods) and small helpers used by the transmitter.
package ir_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    GAP    = 3'd2,
    CARSEL = 3'd3,
    RIGHT  = 3'd4,
    LEFT   = 3'd5,
    BACK   = 3'd6,
    FWD    = 3'd7
  } ir_state_e;

  // Carrier periods per car colour, CLK cycles at 100 MHz (all even).
  localparam int unsigned CARRIER_ORANGE = 32'd2778;  // 36 kHz
  localparam int unsigned CARRIER_YELLOW = 32'd2632;  // 38 kHz
  localparam int unsigned CARRIER_GREEN  = 32'd2500;  // 40 kHz
  localparam int unsigned CARRIER_BLUE   = 32'd2272;  // 44 kHz

  // Default segment lengths in carrier periods.
  localparam int unsigned DEF_START_LEN    = 32'd88;
  localparam int unsigned DEF_GAP_LEN      = 32'd40;
  localparam int unsigned DEF_CARSEL_LEN   = 32'd22;
  localparam int unsigned DEF_ASSERT_LEN   = 32'd44;
  localparam int unsigned DEF_DEASSERT_LEN = 32'd22;

  // True for the states that radiate carrier.
  function automatic logic is_burst(input ir_state_e s);
    return (s != IDLE) && (s != GAP);
  endfunction

  // Larger of two unsigned values, used to size the period counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier phase generator.
// Ports:
//   CLK        system clock
//   RESET      asynchronous active-low reset
//   clear      forces the phase counter to 0 (takes priority over enable)
//   enable     advances the phase counter 0..CARRIER_PERIOD-1 and wraps
//   carrier    1 during the first half of each carrier period
//   period_end one-cycle strobe on the last cycle of each carrier period
module ir_carrier_gen
  import ir_tx_pkg::*;
#(
  parameter int unsigned CARRIER_PERIOD = CARRIER_ORANGE
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  input  logic enable,
  output logic carrier,
  output logic period_end
);

  localparam int unsigned PH_W = (CARRIER_PERIOD > 32'd1) ? $clog2(CARRIER_PERIOD) : 32'd1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CARRIER_PERIOD - 32'd1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(CARRIER_PERIOD / 32'd2);

  logic [PH_W-1:0] phase_r;

  // Phase counter: wraps at the end of each carrier period.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      phase_r <= {PH_W{1'b0}};
    end else if (clear) begin
      phase_r <= {PH_W{1'b0}};
    end else if (enable) begin
      if (phase_r == PH_LAST) begin
        phase_r <= {PH_W{1'b0}};
      end else begin
        phase_r <= phase_r + PH_W'(1);
      end
    end else begin
      phase_r <= phase_r;
    end
  end

  // Carrier level and end-of-period strobe decoded from the phase.
  always_comb begin
    carrier    = (phase_r < PH_HALF);
    period_end = enable & ~clear & (phase_r == PH_LAST);
  end

endmodule

// File: rtl/ir_packet_tx.sv
// IR command packet transmitter for the toy car.
// Each 0->1 transition of SEND_PACKET seen while idle sends one packet:
// START, GAP, CARSEL, GAP, RIGHT, GAP, LEFT, GAP, BACK, GAP, FWD, GAP.
// Command bursts are ASSERT_LEN or DEASSERT_LEN carrier periods long
// according to the COMMAND bit latched at the trigger.
// Ports:
//   CLK          system clock (100 MHz)
//   RESET        asynchronous active-low reset
//   SEND_PACKET  trigger, rising edge starts a packet
//   COMMAND      {forward, backward, left, right}, sampled at the trigger
//   IR_LED       registered modulated IR output
//   BUSY         registered, high while a packet is in flight
module ir_packet_tx
  import ir_tx_pkg::*;
#(
  parameter int unsigned CARRIER_PERIOD = CARRIER_ORANGE,
  parameter int unsigned START_LEN      = DEF_START_LEN,
  parameter int unsigned GAP_LEN        = DEF_GAP_LEN,
  parameter int unsigned CARSEL_LEN     = DEF_CARSEL_LEN,
  parameter int unsigned ASSERT_LEN     = DEF_ASSERT_LEN,
  parameter int unsigned DEASSERT_LEN   = DEF_DEASSERT_LEN
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SEND_PACKET,
  input  logic [3:0] COMMAND,
  output logic       IR_LED,
  output logic       BUSY
);

  localparam int unsigned MAX_LEN = max_u(max_u(max_u(START_LEN, GAP_LEN),
                                                max_u(CARSEL_LEN, ASSERT_LEN)),
                                          DEASSERT_LEN);
  localparam int unsigned PC_W = $clog2(MAX_LEN + 32'd1);

  ir_state_e       state_r, state_s;
  logic [2:0]      seg_idx_r, seg_idx_s;
  logic [3:0]      cmd_r, cmd_s;
  logic [PC_W-1:0] period_cnt_r, period_cnt_s;
  logic [PC_W-1:0] seg_len_s;
  logic            send_prev_r;
  logic            trig_s;
  logic            carrier_s;
  logic            period_end_s;
  logic            clear_s;
  logic            enable_s;
  logic            ir_led_s;
  logic            busy_s;

  // The carrier runs only while a packet is in flight; holding it cleared in
  // IDLE makes every packet start on phase 0. Segment boundaries fall on a
  // period wrap, so later segments also start at phase 0.
  always_comb begin
    clear_s  = (state_r == IDLE);
    enable_s = (state_r != IDLE);
  end

  ir_carrier_gen #(
    .CARRIER_PERIOD(CARRIER_PERIOD)
  ) u_carrier (
    .CLK        (CLK),
    .RESET      (RESET),
    .clear      (clear_s),
    .enable     (enable_s),
    .carrier    (carrier_s),
    .period_end (period_end_s)
  );

  // Length of the current segment in carrier periods.
  always_comb begin
    case (state_r)
      START:   seg_len_s = PC_W'(START_LEN);
      GAP:     seg_len_s = PC_W'(GAP_LEN);
      CARSEL:  seg_len_s = PC_W'(CARSEL_LEN);
      RIGHT:   seg_len_s = cmd_r[0] ? PC_W'(ASSERT_LEN) : PC_W'(DEASSERT_LEN);
      LEFT:    seg_len_s = cmd_r[1] ? PC_W'(ASSERT_LEN) : PC_W'(DEASSERT_LEN);
      BACK:    seg_len_s = cmd_r[2] ? PC_W'(ASSERT_LEN) : PC_W'(DEASSERT_LEN);
      FWD:     seg_len_s = cmd_r[3] ? PC_W'(ASSERT_LEN) : PC_W'(DEASSERT_LEN);
      default: seg_len_s = PC_W'(1);
    endcase
  end

  // Next-state logic: trigger acceptance and segment sequencing.
  always_comb begin
    state_s      = state_r;
    seg_idx_s    = seg_idx_r;
    cmd_s        = cmd_r;
    period_cnt_s = period_cnt_r;
    trig_s       = SEND_PACKET & ~send_prev_r;
    if (state_r == IDLE) begin
      if (trig_s) begin
        state_s      = START;
        cmd_s        = COMMAND;
        seg_idx_s    = 3'd0;
        period_cnt_s = {PC_W{1'b0}};
      end else begin
        state_s = IDLE;
      end
    end else if (period_end_s) begin
      if (period_cnt_r == (seg_len_s - PC_W'(1))) begin
        period_cnt_s = {PC_W{1'b0}};
        case (state_r)
          GAP: begin
            // seg_idx counts completed gaps and picks the burst that follows.
            seg_idx_s = seg_idx_r + 3'd1;
            case (seg_idx_r)
              3'd0:    state_s = CARSEL;
              3'd1:    state_s = RIGHT;
              3'd2:    state_s = LEFT;
              3'd3:    state_s = BACK;
              3'd4:    state_s = FWD;
              default: state_s = IDLE;
            endcase
          end
          START, CARSEL, RIGHT, LEFT, BACK, FWD: state_s = GAP;
          default: state_s = IDLE;
        endcase
      end else begin
        period_cnt_s = period_cnt_r + PC_W'(1);
      end
    end else begin
      period_cnt_s = period_cnt_r;
    end
  end

  // Output decode; registered below so outputs lag the state by one cycle.
  always_comb begin
    ir_led_s = is_burst(state_r) & carrier_s;
    busy_s   = (state_r != IDLE);
  end

  // State, counters, trigger history and registered outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r      <= IDLE;
      seg_idx_r    <= 3'd0;
      cmd_r        <= 4'd0;
      period_cnt_r <= {PC_W{1'b0}};
      // A level already high when reset releases must not count as an edge.
      send_prev_r  <= 1'b1;
      IR_LED       <= 1'b0;
      BUSY         <= 1'b0;
    end else begin
      state_r      <= state_s;
      seg_idx_r    <= seg_idx_s;
      cmd_r        <= cmd_s;
      period_cnt_r <= period_cnt_s;
      send_prev_r  <= SEND_PACKET;
      IR_LED       <= ir_led_s;
      BUSY         <= busy_s;
    end
  end

endmodule
